// File: rtl/vector_issue_ctrl.sv
// ---------------------------------------------------------------------------
// vector_issue_ctrl
//
// Purpose:
//   Upstream feeder of the vector register-file wrapper. Decoded vector
//   instructions arrive over a valid/ready handshake. Each one is checked for
//   register-group alignment against its LMUL. Legal instructions are queued
//   in a small FIFO. Illegal ones are accepted and dropped, and a one-cycle
//   illegal pulse is raised. The FIFO head drives a registered VRF request.
//   The request is held stable until the VRF signals that the whole register
//   group is done. The head is then popped, and the next entry is issued in
//   the following cycle without a gap.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   instr_valid_i/ready_o     decode handshake; ready is a registered !full
//   vs1_i, vs2_i, vd_i        register specifiers of the incoming instruction
//   num_operands_i, we_i      operand count (0-3) and write-enable of vd
//   lmul_i                    LMUL in the RVV encoding
//   vrf_req_o, vrf_*_o        registered request and fields of the FIFO head
//   vrf_done_i                one-cycle completion pulse from the VRF
//   illegal_o                 one-cycle pulse after an illegal transfer
//   busy_o                    FIFO not empty
//   retired_cnt_o             wrapping count of completed instructions
// ---------------------------------------------------------------------------

package vcve2_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

endpackage

module vector_issue_ctrl
    import vcve2_pkg::*;
#(
    parameter int unsigned AddrWidth = 5,   // must be at least 3 for LMUL=8 checks
    parameter int unsigned Depth     = 2,   // power of two, at least 2
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [AddrWidth-1:0] vs1_i,
    input  logic [AddrWidth-1:0] vs2_i,
    input  logic [AddrWidth-1:0] vd_i,
    input  logic [1:0]           num_operands_i,
    input  logic                 we_i,
    input  vlmul_e               lmul_i,
    output logic                 vrf_req_o,
    output logic                 vrf_we_o,
    output logic [AddrWidth-1:0] vrf_raddr_a_o,
    output logic [AddrWidth-1:0] vrf_raddr_b_o,
    output logic [AddrWidth-1:0] vrf_waddr_o,
    output logic [1:0]           vrf_num_operands_o,
    output vlmul_e               vrf_lmul_o,
    input  logic                 vrf_done_i,
    output logic                 illegal_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  retired_cnt_o
);

    localparam int unsigned PtrWidth   = $clog2(Depth);
    localparam int unsigned CountWidth = $clog2(Depth) + 1;

    typedef struct packed {
        logic [AddrWidth-1:0] vs1;
        logic [AddrWidth-1:0] vs2;
        logic [AddrWidth-1:0] vd;
        logic [1:0]           num_ops;
        logic                 we;
        vlmul_e               lmul;
    } entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // A specifier is aligned when its low log2(LMUL) bits are zero.
    // Fractional LMUL and LMUL=1 place no constraint.
    function automatic logic is_aligned(input logic [AddrWidth-1:0] addr,
                                        input vlmul_e               lmul);
        logic ok;
        ok = 1'b1;
        case (lmul)
            LMUL_2:  ok = (addr[0]   == 1'b0);
            LMUL_4:  ok = (addr[1:0] == 2'b00);
            LMUL_8:  ok = (addr[2:0] == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Storage and state
    entry_t                fifo_mem_r [Depth];
    logic [PtrWidth-1:0]   wr_ptr_r;
    logic [PtrWidth-1:0]   rd_ptr_r;
    logic [CountWidth-1:0] count_r;
    logic                  ready_r;
    state_e                state_r;
    logic                  req_r;
    entry_t                head_out_r;
    logic                  illegal_r;
    logic [CntWidth-1:0]   retired_r;

    // Combinational next-state signals
    entry_t                in_entry_s;
    entry_t                head_nxt_s;
    logic                  legal_s;
    logic                  xfer_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CountWidth-1:0] count_nxt_s;
    logic [CountWidth-1:0] count_after_pop_s;
    logic [PtrWidth-1:0]   rd_ptr_nxt_s;
    logic [PtrWidth-1:0]   wr_ptr_nxt_s;

    // Pack the incoming instruction and decide its legality
    always_comb begin
        in_entry_s.vs1     = vs1_i;
        in_entry_s.vs2     = vs2_i;
        in_entry_s.vd      = vd_i;
        in_entry_s.num_ops = num_operands_i;
        in_entry_s.we      = we_i;
        in_entry_s.lmul    = lmul_i;

        legal_s = (lmul_i != LMUL_RSVD)
               && ((num_operands_i < 2'd1) || is_aligned(vs1_i, lmul_i))
               && ((num_operands_i < 2'd2) || is_aligned(vs2_i, lmul_i))
               && (!(we_i || (num_operands_i == 2'd3)) || is_aligned(vd_i, lmul_i));
    end

    // Handshake, push/pop and pointer/occupancy updates
    always_comb begin
        xfer_s = instr_valid_i && ready_r;
        push_s = xfer_s && legal_s;
        pop_s  = (state_r == ST_ISSUE) && vrf_done_i;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CountWidth'(1);
            2'b01:   count_nxt_s = count_r - CountWidth'(1);
            default: count_nxt_s = count_r;
        endcase

        if (pop_s) begin
            count_after_pop_s = count_r - CountWidth'(1);
            rd_ptr_nxt_s      = rd_ptr_r + PtrWidth'(1);
        end else begin
            count_after_pop_s = count_r;
            rd_ptr_nxt_s      = rd_ptr_r;
        end

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PtrWidth'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Next head: if the queue would be empty without this cycle's push, the
    // new head is the incoming instruction itself (not yet in storage).
    always_comb begin
        head_nxt_s = in_entry_s;
        if (count_after_pop_s == CountWidth'(0)) begin
            head_nxt_s = in_entry_s;
        end else begin
            head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // Issue FSM with registered request, fields, ready, pulse and counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            req_r      <= 1'b0;
            head_out_r <= '0;
            wr_ptr_r   <= PtrWidth'(0);
            rd_ptr_r   <= PtrWidth'(0);
            count_r    <= CountWidth'(0);
            ready_r    <= 1'b1;
            illegal_r  <= 1'b0;
            retired_r  <= CntWidth'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (push_s) begin
                        state_r <= ST_ISSUE;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (pop_s && (count_nxt_s == CountWidth'(0))) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= ST_ISSUE;
                        req_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase

            // Fields follow the head whenever one exists; they hold otherwise,
            // with req low so the VRF ignores them.
            if (count_nxt_s != CountWidth'(0)) begin
                head_out_r <= head_nxt_s;
            end else begin
                head_out_r <= head_out_r;
            end

            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            // Ready depends only on registered occupancy, never on inputs
            // in the same cycle.
            ready_r   <= (count_nxt_s != CountWidth'(Depth));
            illegal_r <= xfer_s && !legal_s;

            if (pop_s) begin
                retired_r <= retired_r + CntWidth'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign instr_ready_o      = ready_r;
    assign vrf_req_o          = req_r;
    assign vrf_we_o           = head_out_r.we;
    assign vrf_raddr_a_o      = head_out_r.vs1;
    assign vrf_raddr_b_o      = head_out_r.vs2;
    assign vrf_waddr_o        = head_out_r.vd;
    assign vrf_num_operands_o = head_out_r.num_ops;
    assign vrf_lmul_o         = head_out_r.lmul;
    assign illegal_o          = illegal_r;
    assign busy_o             = (count_r != CountWidth'(0));
    assign retired_cnt_o      = retired_r;

endmodule

// File: doc/vector_issue_ctrl.md
Name: vector_issue_ctrl

Overview:
Upstream feeder of the vector register-file wrapper. It accepts decoded vector instructions from the decode stage through a valid/ready handshake and buffers them in a small FIFO. It checks register-group alignment for the LMUL setting. It drives the VRF request and operand fields from the FIFO head, holding them stable until the VRF reports completion of the whole register group. It then pops the head and issues the next instruction back-to-back.

Parameters:
AddrWidth, 5, width of vector register specifiers.
Depth, 2, instruction FIFO entries; power of two, at least 2.
CntWidth, 16, width of the retired-instruction counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  synchronous, active-high reset.
instr_valid_i  input  1  decode presents an instruction.
instr_ready_o  output  1  FIFO can accept; equals !full, with no combinational path from any input.
vs1_i  input  AddrWidth  source register A.
vs2_i  input  AddrWidth  source register B.
vd_i  input  AddrWidth  destination register; also the third-operand source.
num_operands_i  input  2  number of source operands (0–3).
we_i  input  1  instruction writes vd.
lmul_i  input  vcve2_pkg::vlmul_e  LMUL; RVV encoding (000=1, 001=2, 010=4, 011=8, 101=F8, 110=F4, 111=F2, 100 reserved).
vrf_req_o  output  1  request to the VRF wrapper.
vrf_we_o  output  1  write enable from the head entry.
vrf_raddr_a_o  output  AddrWidth  head vs1.
vrf_raddr_b_o  output  AddrWidth  head vs2.
vrf_waddr_o  output  AddrWidth  head vd.
vrf_num_operands_o  output  2  head operand count.
vrf_lmul_o  output  vlmul_e  head LMUL.
vrf_done_i  input  1  one-cycle pulse from the VRF: whole register group finished.
illegal_o  output  1  one-cycle pulse: an instruction was accepted and dropped as illegal.
busy_o  output  1  FIFO not empty.
retired_cnt_o  output  CntWidth  count of completed instructions; wraps.

Behaviour:
- Reset state, applied at the first rising edge with rst_i high:
  - FIFO empty, so instr_ready_o=1 and busy_o=0.
  - vrf_req_o=0, illegal_o=0, retired_cnt_o=0.
  - All vrf_* field outputs are 0.
- Handshake: a transfer occurs when instr_valid_i && instr_ready_o. Inputs are sampled at that edge.
- Legality check, combinational on the inputs at transfer time:
  - lmul_i == 100 is illegal.
  - For LMUL 2/4/8, each used specifier must be a multiple of 2/4/8:
    - vs1 is checked if num_operands_i ≥ 1.
    - vs2 is checked if num_operands_i ≥ 2.
    - vd is checked if we_i or num_operands_i == 3.
  - Fractional LMUL and LMUL 1 need no alignment.
- Illegal transfer: the instruction is not enqueued, and illegal_o=1 for exactly the following cycle. The handshake still completes, so decode never stalls on an illegal instruction.
- Legal transfer: the instruction is enqueued at the tail; write pointer +1 mod Depth.
- State machine (per head):
  - IDLE: FIFO empty, vrf_req_o=0. Moves to ISSUE when an entry is enqueued; vrf_req_o becomes 1 on the cycle after the enqueue edge.
  - ISSUE: vrf_req_o=1. All vrf_* fields equal the head entry and are held stable.
  - On vrf_done_i=1 in ISSUE:
    - The head is popped at that edge and retired_cnt_o increments (wraps at 2^CntWidth).
    - If another entry remains, including one enqueued in the same cycle, stay in ISSUE with the fields switched to the new head on the next cycle (back-to-back).
    - Otherwise go to IDLE and drop vrf_req_o to 0 on the next cycle.
- Output registering: vrf_req_o and the fields are registered outputs, so the VRF sees req low, or a new head, in the cycle its FSM returns to idle. The VRF must never re-sample a popped instruction.
- vrf_done_i while not in ISSUE: ignored, with no pop and no count.
- Simultaneous enqueue and pop:
  - Both happen; occupancy is unchanged.
  - Enqueue when full is impossible because instr_ready_o=0; ready does not look at vrf_done_i.
  - Full-and-popping raises instr_ready_o on the next cycle.
- Pointers wrap modulo Depth. Occupancy is tracked with a count register of width clog2(Depth)+1.
- Reset mid-operation: FIFO flushed, state IDLE, vrf_req_o=0 the next cycle, counter cleared. The VRF wrapper is reset by the same system reset.

Test Plan:
1. Reset → instr_ready_o=1, vrf_req_o=0, busy_o=0, retired_cnt_o=0.
2. Legal LMUL=1, vs1=3, vs2=4, vd=5, 2 operands, we=1 → next cycle vrf_req_o=1 with raddr_a=3, raddr_b=4, waddr=5, num_operands=2. Fields stay stable; done pulse → req=0 next cycle, retired_cnt_o=1.
3. LMUL=4 with vs1=6 and 1 operand → illegal_o pulses one cycle, no request issued, ready stays 1. Repeat with vs1=8 → issued.
4. Three back-to-back legal instructions with Depth=2 → ready=0 after the second is accepted. The first done pops, the head switches without req dropping, and the third is accepted. After three dones retired_cnt_o=3, req=0.
5. lmul_i=100 → illegal_o=1, FIFO unchanged. LMUL=8, vd=16, we=1, 0 operands → legal.
6. Assert rst_i mid-ISSUE with 2 entries queued → next cycle FIFO empty, req=0, ready=1. A stray vrf_done_i after reset → no count change.
